// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared encodings for the ALU issue front end: ALU operation
//            codes, MIPS opcode/funct values, FSM states, response flags.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation encoding (5-bit OPcode of the ALU)
  localparam logic [4:0] C_ALU_ADD = 5'd0;
  localparam logic [4:0] C_ALU_SUB = 5'd1;
  localparam logic [4:0] C_ALU_MUL = 5'd2;
  localparam logic [4:0] C_ALU_DIV = 5'd3;
  localparam logic [4:0] C_ALU_NOT = 5'd4;
  localparam logic [4:0] C_ALU_AND = 5'd5;
  localparam logic [4:0] C_ALU_OR  = 5'd6;
  localparam logic [4:0] C_ALU_XOR = 5'd7;
  localparam logic [4:0] C_ALU_SLL = 5'd8;
  localparam logic [4:0] C_ALU_SRL = 5'd9;
  localparam logic [4:0] C_ALU_SLT = 5'd10;
  localparam logic [4:0] C_ALU_SGT = 5'd11;
  localparam logic [4:0] C_ALU_SEQ = 5'd12;
  localparam logic [4:0] C_ALU_SLE = 5'd13;
  localparam logic [4:0] C_ALU_SGE = 5'd14;
  localparam logic [4:0] C_ALU_SNE = 5'd15;

  // MIPS primary opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_ADDIU = 6'h09;
  localparam logic [5:0] C_OP_SLTI  = 6'h0A;
  localparam logic [5:0] C_OP_ANDI  = 6'h0C;
  localparam logic [5:0] C_OP_ORI   = 6'h0D;
  localparam logic [5:0] C_OP_XORI  = 6'h0E;

  // MIPS R-type funct codes
  localparam logic [5:0] C_FN_SLL  = 6'h00;
  localparam logic [5:0] C_FN_SRL  = 6'h02;
  localparam logic [5:0] C_FN_MULT = 6'h18;
  localparam logic [5:0] C_FN_DIV  = 6'h1A;
  localparam logic [5:0] C_FN_ADD  = 6'h20;
  localparam logic [5:0] C_FN_ADDU = 6'h21;
  localparam logic [5:0] C_FN_SUB  = 6'h22;
  localparam logic [5:0] C_FN_SUBU = 6'h23;
  localparam logic [5:0] C_FN_AND  = 6'h24;
  localparam logic [5:0] C_FN_OR   = 6'h25;
  localparam logic [5:0] C_FN_XOR  = 6'h26;
  localparam logic [5:0] C_FN_SLT  = 6'h2A;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Which ALU overflow flag (if any) becomes the trap
  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0,
    TRAP_ADD  = 2'd1,
    TRAP_SUB  = 2'd2
  } trap_sel_t;

  // Response flag bundle
  typedef struct packed {
    logic zero;
    logic ovf_trap;
    logic div0;
    logic illegal;
  } rsp_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode
// Purpose  : Combinational MIPS-to-ALU translation: operation code, operands
//            (with immediate extension), shift amount, trap selection,
//            divide detection and illegal-instruction detection.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [4:0]        i_shamt,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic [15:0]       i_imm,
  output logic [4:0]        o_alu_opcode,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [4:0]        o_shamt,
  output logic              o_is_illegal,
  output trap_sel_t         o_trap_sel,
  output logic              o_is_div
);

  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;

  assign w_imm_sext = {{(DATA_W-16){i_imm[15]}}, i_imm};
  assign w_imm_zext = {{(DATA_W-16){1'b0}}, i_imm};

  // Decode table; unknown encodings collapse to an all-zero illegal result
  always_comb begin
    o_alu_opcode = C_ALU_ADD;
    o_op1        = i_rs;
    o_op2        = i_rt;
    o_shamt      = 5'd0;
    o_is_illegal = 1'b0;
    o_trap_sel   = TRAP_NONE;
    o_is_div     = 1'b0;

    case (i_opcode)
      C_OP_RTYPE: begin
        case (i_funct)
          C_FN_ADD: begin
            o_alu_opcode = C_ALU_ADD;
            o_trap_sel   = TRAP_ADD;
          end
          C_FN_ADDU: o_alu_opcode = C_ALU_ADD;
          C_FN_SUB: begin
            o_alu_opcode = C_ALU_SUB;
            o_trap_sel   = TRAP_SUB;
          end
          C_FN_SUBU: o_alu_opcode = C_ALU_SUB;
          C_FN_AND:  o_alu_opcode = C_ALU_AND;
          C_FN_OR:   o_alu_opcode = C_ALU_OR;
          C_FN_XOR:  o_alu_opcode = C_ALU_XOR;
          C_FN_SLT:  o_alu_opcode = C_ALU_SLT;
          C_FN_MULT: o_alu_opcode = C_ALU_MUL;
          C_FN_DIV: begin
            o_alu_opcode = C_ALU_DIV;
            o_is_div     = 1'b1;
          end
          C_FN_SLL: begin
            o_alu_opcode = C_ALU_SLL;
            o_op1        = i_rt;
            o_shamt      = i_shamt;
          end
          C_FN_SRL: begin
            o_alu_opcode = C_ALU_SRL;
            o_op1        = i_rt;
            o_shamt      = i_shamt;
          end
          default: o_is_illegal = 1'b1;
        endcase
      end
      C_OP_ADDI: begin
        o_alu_opcode = C_ALU_ADD;
        o_op2        = w_imm_sext;
        o_trap_sel   = TRAP_ADD;
      end
      C_OP_ADDIU: begin
        o_alu_opcode = C_ALU_ADD;
        o_op2        = w_imm_sext;
      end
      C_OP_SLTI: begin
        o_alu_opcode = C_ALU_SLT;
        o_op2        = w_imm_sext;
      end
      C_OP_ANDI: begin
        o_alu_opcode = C_ALU_AND;
        o_op2        = w_imm_zext;
      end
      C_OP_ORI: begin
        o_alu_opcode = C_ALU_OR;
        o_op2        = w_imm_zext;
      end
      C_OP_XORI: begin
        o_alu_opcode = C_ALU_XOR;
        o_op2        = w_imm_zext;
      end
      C_OP_BEQ: o_alu_opcode = C_ALU_SEQ;
      C_OP_BNE: o_alu_opcode = C_ALU_SNE;
      default:  o_is_illegal = 1'b1;
    endcase

    if (o_is_illegal) begin
      o_alu_opcode = C_ALU_ADD;
      o_op1        = '0;
      o_op2        = '0;
      o_shamt      = 5'd0;
      o_trap_sel   = TRAP_NONE;
      o_is_div     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_issuer
// Purpose  : Execute-stage front end for the external 5-bit-opcode ALU.
//            Accepts one decoded instruction per handshake, holds the ALU
//            inputs for one execute cycle, captures result and flags and
//            returns them on a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_opcode,
  input  logic [5:0]        cmd_funct,
  input  logic [4:0]        cmd_shamt,
  input  logic [DATA_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_rt,
  input  logic [15:0]       cmd_imm,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovf_add,
  input  logic              alu_ovf_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_ovf_trap,
  output logic              rsp_div0,
  output logic              rsp_illegal
);

  // Decoder outputs
  logic [4:0]        w_dec_alu_opcode;
  logic [DATA_W-1:0] w_dec_op1;
  logic [DATA_W-1:0] w_dec_op2;
  logic [4:0]        w_dec_shamt;
  logic              w_dec_is_illegal;
  trap_sel_t         w_dec_trap_sel;
  logic              w_dec_is_div;
  logic              w_accept;

  // Registered state
  state_t            r_state;
  logic [4:0]        r_alu_opcode;
  logic [DATA_W-1:0] r_alu_op1;
  logic [DATA_W-1:0] r_alu_op2;
  logic [4:0]        r_alu_shamt;
  trap_sel_t         r_trap_sel;
  logic              r_div0;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  rsp_flags_t        r_rsp_flags;

  alu_op_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .i_opcode     (cmd_opcode),
    .i_funct      (cmd_funct),
    .i_shamt      (cmd_shamt),
    .i_rs         (cmd_rs),
    .i_rt         (cmd_rt),
    .i_imm        (cmd_imm),
    .o_alu_opcode (w_dec_alu_opcode),
    .o_op1        (w_dec_op1),
    .o_op2        (w_dec_op2),
    .o_shamt      (w_dec_shamt),
    .o_is_illegal (w_dec_is_illegal),
    .o_trap_sel   (w_dec_trap_sel),
    .o_is_div     (w_dec_is_div)
  );

  // Ready depends only on the registered state, never on rsp_ready
  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && (r_state == ST_IDLE);

  assign alu_opcode   = r_alu_opcode;
  assign alu_op1      = r_alu_op1;
  assign alu_op2      = r_alu_op2;
  assign alu_shamt    = r_alu_shamt;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_flags.zero;
  assign rsp_ovf_trap = r_rsp_flags.ovf_trap;
  assign rsp_div0     = r_rsp_flags.div0;
  assign rsp_illegal  = r_rsp_flags.illegal;

  // Issue FSM: latch ALU inputs on accept, capture ALU outputs after EXEC,
  // hold the response until the consumer takes it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_alu_opcode <= 5'd0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_shamt  <= 5'd0;
      r_trap_sel   <= TRAP_NONE;
      r_div0       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_opcode <= w_dec_alu_opcode;
            r_alu_op1    <= w_dec_op1;
            r_alu_op2    <= w_dec_op2;
            r_alu_shamt  <= w_dec_shamt;
            r_trap_sel   <= w_dec_trap_sel;
            r_div0       <= w_dec_is_div && (cmd_rt == '0);
            if (w_dec_is_illegal) begin
              // Illegal instructions skip the ALU and answer immediately
              r_state              <= ST_RESP;
              r_rsp_valid          <= 1'b1;
              r_rsp_result         <= '0;
              r_rsp_flags          <= '0;
              r_rsp_flags.zero     <= 1'b1;
              r_rsp_flags.illegal  <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_state               <= ST_RESP;
          r_rsp_valid           <= 1'b1;
          r_rsp_result          <= alu_result;
          r_rsp_flags.zero      <= alu_zero;
          r_rsp_flags.ovf_trap  <= (r_trap_sel == TRAP_ADD) ? alu_ovf_add :
                                   (r_trap_sel == TRAP_SUB) ? alu_ovf_sub : 1'b0;
          r_rsp_flags.div0      <= r_div0;
          r_rsp_flags.illegal   <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_issuer
// Purpose  : Self-checking bench for alu_op_issuer with an external ALU model
//            and an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_issuer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode = 6'd0;
  logic [5:0]  cmd_funct = 6'd0;
  logic [4:0]  cmd_shamt = 5'd0;
  logic [31:0] cmd_rs = 32'd0;
  logic [31:0] cmd_rt = 32'd0;
  logic [15:0] cmd_imm = 16'd0;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ovf_add;
  logic        alu_ovf_sub;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_ovf_trap;
  logic        rsp_div0;
  logic        rsp_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_op_issuer #(.DATA_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_funct    (cmd_funct),
    .cmd_shamt    (cmd_shamt),
    .cmd_rs       (cmd_rs),
    .cmd_rt       (cmd_rt),
    .cmd_imm      (cmd_imm),
    .alu_opcode   (alu_opcode),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_ovf_add  (alu_ovf_add),
    .alu_ovf_sub  (alu_ovf_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_ovf_trap (rsp_ovf_trap),
    .rsp_div0     (rsp_div0),
    .rsp_illegal  (rsp_illegal)
  );

  // Signed divide with the ALU's zero-divisor substitution; -1 handled as negate
  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    if (d == 32'hFFFF_FFFF) return -a;
    return $signed(a) / $signed(d);
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a - b;
    return (a[31] != b[31]) && (s[31] != a[31]);
  endfunction

  // External ALU beside the issuer
  always_comb begin
    alu_result = 32'd0;
    case (alu_opcode)
      5'd0:  alu_result = alu_op1 + alu_op2;
      5'd1:  alu_result = alu_op1 - alu_op2;
      5'd2:  alu_result = alu_op1 * alu_op2;
      5'd3:  alu_result = sdiv(alu_op1, alu_op2);
      5'd4:  alu_result = ~alu_op1;
      5'd5:  alu_result = alu_op1 & alu_op2;
      5'd6:  alu_result = alu_op1 | alu_op2;
      5'd7:  alu_result = alu_op1 ^ alu_op2;
      5'd8:  alu_result = alu_op1 << alu_shamt;
      5'd9:  alu_result = alu_op1 >> alu_shamt;
      5'd10: alu_result = {31'd0, $signed(alu_op1) <  $signed(alu_op2)};
      5'd11: alu_result = {31'd0, $signed(alu_op1) >  $signed(alu_op2)};
      5'd12: alu_result = {31'd0, alu_op1 == alu_op2};
      5'd13: alu_result = {31'd0, $signed(alu_op1) <= $signed(alu_op2)};
      5'd14: alu_result = {31'd0, $signed(alu_op1) >= $signed(alu_op2)};
      5'd15: alu_result = {31'd0, alu_op1 != alu_op2};
      default: alu_result = 32'd0;
    endcase
    alu_zero    = (alu_result == 32'd0);
    alu_ovf_add = add_ovf(alu_op1, alu_op2);
    alu_ovf_sub = sub_ovf(alu_op1, alu_op2);
  end

  typedef struct packed {
    logic        illegal;
    logic [4:0]  aop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  ash;
    logic [31:0] result;
    logic        zero;
    logic        trap;
    logic        div0;
  } exp_t;

  // Instruction-level reference: MIPS semantics computed directly
  function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] sh, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [15:0] imm);
    exp_t e;
    logic [31:0] se;
    logic [31:0] ze;
    e  = '0;
    se = {{16{imm[15]}}, imm};
    ze = {16'd0, imm};
    e.op1 = rs;
    e.op2 = rt;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin e.aop = 5'd0; e.result = rs + rt; e.trap = (fn == 6'h20) && add_ovf(rs, rt); end
        6'h22, 6'h23: begin e.aop = 5'd1; e.result = rs - rt; e.trap = (fn == 6'h22) && sub_ovf(rs, rt); end
        6'h24: begin e.aop = 5'd5;  e.result = rs & rt; end
        6'h25: begin e.aop = 5'd6;  e.result = rs | rt; end
        6'h26: begin e.aop = 5'd7;  e.result = rs ^ rt; end
        6'h2A: begin e.aop = 5'd10; e.result = {31'd0, $signed(rs) < $signed(rt)}; end
        6'h00: begin e.aop = 5'd8;  e.op1 = rt; e.ash = sh; e.result = rt << sh; end
        6'h02: begin e.aop = 5'd9;  e.op1 = rt; e.ash = sh; e.result = rt >> sh; end
        6'h18: begin e.aop = 5'd2;  e.result = rs * rt; end
        6'h1A: begin e.aop = 5'd3;  e.result = sdiv(rs, rt); e.div0 = (rt == 32'd0); end
        default: e.illegal = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin e.aop = 5'd0; e.op2 = se; e.result = rs + se; e.trap = (op == 6'h08) && add_ovf(rs, se); end
        6'h0A: begin e.aop = 5'd10; e.op2 = se; e.result = {31'd0, $signed(rs) < $signed(se)}; end
        6'h0C: begin e.aop = 5'd5;  e.op2 = ze; e.result = rs & ze; end
        6'h0D: begin e.aop = 5'd6;  e.op2 = ze; e.result = rs | ze; end
        6'h0E: begin e.aop = 5'd7;  e.op2 = ze; e.result = rs ^ ze; end
        6'h04: begin e.aop = 5'd12; e.result = {31'd0, rs == rt}; end
        6'h05: begin e.aop = 5'd15; e.result = {31'd0, rs != rt}; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (e.illegal) begin
      e.result = 32'd0;
      e.zero   = 1'b1;
      e.trap   = 1'b0;
      e.div0   = 1'b0;
    end else begin
      e.zero = (e.result == 32'd0);
    end
    return e;
  endfunction

  // Present a command and wait (bounded) for its accept edge; returns 1 ns after it
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      output bit ok);
    ok = 1'b0;
    @(negedge clock);
    cmd_opcode = op; cmd_funct = fn; cmd_shamt = sh;
    cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout got=cmd_ready_low exp=accept_within_20");
    end
  endtask

  // Complete the response handshake
  task automatic take_rsp();
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({cmd_ready, rsp_valid, alu_opcode, alu_op1, alu_op2, alu_shamt} !== {1'b1, 1'b0, 5'd0, 64'd0, 5'd0}) begin
      bad++;
      $display("FAIL reset_ctrl got=%h exp=%h", {cmd_ready, rsp_valid, alu_opcode, alu_op1, alu_op2, alu_shamt},
               {1'b1, 1'b0, 5'd0, 64'd0, 5'd0});
    end
    total++;
    if ({rsp_result, rsp_zero, rsp_ovf_trap, rsp_div0, rsp_illegal} !== 36'd0) begin
      bad++;
      $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_zero, rsp_ovf_trap, rsp_div0, rsp_illegal});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got=%b%b exp=10", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_addi_trap();
    bit ok;
    send(6'h08, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'd0, 16'h0001, ok);
    if (ok) begin
      total++;
      if (alu_opcode !== 5'd0 || alu_op2 !== 32'h0000_0001 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL addi_issue got=op%0d op2=%h v=%b r=%b exp=op0 op2=00000001 v=0 r=0",
                 alu_opcode, alu_op2, rsp_valid, cmd_ready);
      end
      @(posedge clock); #1;
      total++;
      if ({rsp_valid, rsp_result, rsp_ovf_trap, rsp_zero} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL addi_rsp got=v%b %h trap%b z%b exp=v1 80000000 trap1 z0",
                 rsp_valid, rsp_result, rsp_ovf_trap, rsp_zero);
      end
      take_rsp();
    end
  endtask

  task automatic test_andi_zext();
    bit ok;
    send(6'h0C, 6'h00, 5'd0, 32'hFFFF_1234, 32'd0, 16'h8F0F, ok);
    if (ok) begin
      total++;
      if (alu_op2 !== 32'h0000_8F0F || alu_opcode !== 5'd5) begin
        bad++;
        $display("FAIL andi_op2 got=%h op%0d exp=00008f0f op5", alu_op2, alu_opcode);
      end
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_0204) begin
        bad++;
        $display("FAIL andi_rsp got=v%b %h exp=v1 00000204", rsp_valid, rsp_result);
      end
      take_rsp();
    end
  endtask

  task automatic test_sll_stall();
    bit ok;
    send(6'h00, 6'h00, 5'd4, 32'hDEAD_BEEF, 32'h0000_0003, 16'h0000, ok);
    if (ok) begin
      total++;
      if (alu_opcode !== 5'd8 || alu_op1 !== 32'h3 || alu_shamt !== 5'd4) begin
        bad++;
        $display("FAIL sll_issue got=op%0d op1=%h sh=%0d exp=op8 op1=3 sh=4", alu_opcode, alu_op1, alu_shamt);
      end
      @(posedge clock); #1;
      for (int i = 0; i < 5; i++) begin
        total++;
        if ({rsp_valid, cmd_ready, rsp_result, alu_opcode, alu_op1, alu_shamt} !==
            {1'b1, 1'b0, 32'h30, 5'd8, 32'h3, 5'd4}) begin
          bad++;
          $display("FAIL sll_stall%0d got=v%b r%b %h op%0d exp=v1 r0 00000030 op8", i,
                   rsp_valid, cmd_ready, rsp_result, alu_opcode);
        end
        @(posedge clock); #1;
      end
      take_rsp();
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL sll_release got=v%b r%b exp=v0 r1", rsp_valid, cmd_ready);
      end
    end
  endtask

  task automatic test_div_and_unsigned();
    bit ok;
    send(6'h00, 6'h1A, 5'd0, 32'd10, 32'd0, 16'h0000, ok);
    if (ok) begin
      @(posedge clock); #1;
      total++;
      if ({rsp_valid, rsp_result, rsp_div0, rsp_ovf_trap} !== {1'b1, 32'd10, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL div0 got=v%b %h d%b t%b exp=v1 0000000a d1 t0", rsp_valid, rsp_result, rsp_div0, rsp_ovf_trap);
      end
      take_rsp();
    end
    send(6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0000, ok);
    if (ok) begin
      @(posedge clock); #1;
      total++;
      if ({rsp_result, rsp_ovf_trap, rsp_div0} !== {32'h8000_0000, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL addu_notrap got=%h t%b d%b exp=80000000 t0 d0", rsp_result, rsp_ovf_trap, rsp_div0);
      end
      take_rsp();
    end
    send(6'h00, 6'h22, 5'd0, 32'h8000_0000, 32'd1, 16'h0000, ok);
    if (ok) begin
      @(posedge clock); #1;
      total++;
      if ({rsp_result, rsp_ovf_trap} !== {32'h7FFF_FFFF, 1'b1}) begin
        bad++;
        $display("FAIL sub_trap got=%h t%b exp=7fffffff t1", rsp_result, rsp_ovf_trap);
      end
      take_rsp();
    end
  endtask

  task automatic test_illegal();
    bit ok;
    send(6'h3F, 6'h00, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 16'hFFFF, ok);
    if (ok) begin
      total++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_ovf_trap, rsp_div0} !==
          {1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL illegal_rsp got=v%b %h z%b i%b t%b d%b exp=v1 00000000 z1 i1 t0 d0",
                 rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_ovf_trap, rsp_div0);
      end
      take_rsp();
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    send(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 16'h0000, ok);
    if (ok) begin
      reset_n = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_exec got=v%b r%b exp=v0 r1", rsp_valid, cmd_ready);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          bad++;
          $display("FAIL reset_discard%0d got=v%b r%b exp=v0 r1", i, rsp_valid, cmd_ready);
        end
      end
    end
    send(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 16'h0000, ok);
    if (ok) begin
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
        bad++;
        $display("FAIL beq_after_reset got=v%b %h z%b exp=v1 00000001 z0", rsp_valid, rsp_result, rsp_zero);
      end
      take_rsp();
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [5:0]  rfn [0:11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A};
    logic [5:0]  iop [0:7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05};
    logic [5:0]  bop [0:3]  = '{6'h3F, 6'h02, 6'h23, 6'h01};
    logic [5:0]  bfn [0:2]  = '{6'h01, 6'h03, 6'h27};
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    exp_t        e;
    bit          ok;
    int          k;
    for (int it = 0; it < 150; it++) begin
      k   = int'($urandom_range(0, 22));
      fn  = 6'($urandom);
      sh  = 5'($urandom);
      imm = 16'($urandom);
      rs  = pick_val();
      rt  = pick_val();
      if (k < 12) begin op = 6'h00; fn = rfn[k]; end
      else if (k < 20) op = iop[k-12];
      else if (k == 20) begin op = 6'h00; fn = bfn[$urandom_range(0, 2)]; end
      else op = bop[$urandom_range(0, 3)];
      if (op == 6'h00 && fn == 6'h1A && rt == 32'hFFFF_FFFF) rt = 32'd3;
      e = ref_model(op, fn, sh, rs, rt, imm);
      send(op, fn, sh, rs, rt, imm, ok);
      if (!ok) continue;
      if (!e.illegal) begin
        total++;
        if ({alu_opcode, alu_op1, alu_op2, alu_shamt, rsp_valid, cmd_ready} !==
            {e.aop, e.op1, e.op2, e.ash, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL rnd_issue it=%0d op=%h fn=%h got=%0d %h %h %0d v%b exp=%0d %h %h %0d v0", it, op, fn,
                   alu_opcode, alu_op1, alu_op2, alu_shamt, rsp_valid, e.aop, e.op1, e.op2, e.ash);
        end
        @(posedge clock); #1;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      total++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_ovf_trap, rsp_div0, rsp_illegal} !==
          {1'b1, e.result, e.zero, e.trap, e.div0, e.illegal}) begin
        bad++;
        $display("FAIL rnd_rsp it=%0d op=%h fn=%h rs=%h rt=%h imm=%h got=v%b %h z%b t%b d%b i%b exp=v1 %h z%b t%b d%b i%b",
                 it, op, fn, rs, rt, imm, rsp_valid, rsp_result, rsp_zero, rsp_ovf_trap, rsp_div0, rsp_illegal,
                 e.result, e.zero, e.trap, e.div0, e.illegal);
      end
      take_rsp();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_addi_trap();
    test_andi_zext();
    test_sll_stall();
    test_div_and_unsigned();
    test_illegal();
    test_reset_mid_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
